pop_referee: RTL and testbench
==============================

POP_REFEREE -- requirements
Module: pop_referee

Interface
REQ-001 Parameter LINE_SIZE, default 12, width of one FIFO data line.
REQ-002 Parameter NUM_SRC, default 4, number of upstream FIFOs served; fixed at 4 (2-bit grant).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 init  input  1  request to enter INIT state.
REQ-006 src_data  input  NUM_SRC*LINE_SIZE  upstream FIFO data_out lines; source i occupies bits [i*LINE_SIZE +: LINE_SIZE].
REQ-007 src_empty  input  NUM_SRC  upstream FIFO empty_f flags, bit i = source i.
REQ-008 dst_almost_full  input  1  downstream FIFO almost_full flag.
REQ-009 state  output  4  one-hot FIFO control state: RESET 4'b0001, INIT 4'b0010, IDLE 4'b0100, ACTIVE 4'b1000.
REQ-010 src_pop  output  NUM_SRC  one-hot pop strobe to upstream FIFOs.
REQ-011 dst_push  output  1  push strobe to downstream FIFO.
REQ-012 dst_data  output  LINE_SIZE  data line pushed downstream.
REQ-013 grant  output  2  index of last source popped.
REQ-014 push_count  output  8  number of lines pushed downstream since reset.

Function
REQ-015 FSM transitions: RESET -> INIT on first clock after reset deasserts; INIT -> IDLE when init=0; IDLE -> ACTIVE when any src_empty bit=0; ACTIVE -> IDLE when all src_empty=1 and no pop issued in current cycle.
REQ-016 init=1 in IDLE or ACTIVE forces INIT next cycle; any pop issued in that cycle completes normally (its push still occurs).
REQ-017 Pops issued only in ACTIVE, only when dst_almost_full=0, at most one src_pop bit high per cycle.
REQ-018 Source eligible when src_empty bit=0 and it was not popped in the previous cycle (empty_f lags one cycle).
REQ-019 Round-robin: priority search starts at (grant+1) mod 4, ascending with wrap; grant updates to the popped index at the edge ending the pop cycle.
REQ-020 Pop in cycle N -> dst_push=1 in cycle N+1, dst_data = src_data slice of that source sampled in N+1 (registered select).
REQ-021 dst_push=1 exactly once per pop; never without a preceding pop.
REQ-022 dst_almost_full=1 stops new pops the same cycle; push for a pop issued in the prior cycle still occurs.
REQ-023 dst_data holds its last value when dst_push=0.
REQ-024 push_count increments by 1 per dst_push, wraps 255 -> 0.
REQ-025 src_pop and dst_push are 0 in RESET, INIT, IDLE except the trailing push of REQ-016/REQ-022.

Reset
REQ-026 reset=1 asynchronously sets: state=4'b0001, src_pop=0, dst_push=0, dst_data=0, grant=2'd3 (first search starts at source 0), push_count=0, pop-pending and last-popped registers cleared.
REQ-027 reset mid-operation drops any pending push; no dst_push after reset asserts.

Verification
REQ-028 Reset release with init=1 for 3 cycles, all sources empty -> state 0001, 0010 x3, then 0100 and holds.
REQ-029 All 4 sources non-empty, dst_almost_full=0 -> src_pop sequence 0001,0010,0100,1000,0001; dst_push one cycle after each, dst_data matches granted slice.
REQ-030 Only source 2 non-empty for 4 cycles -> src_pop=0100 on alternating cycles only; push_count +2.
REQ-031 dst_almost_full rises while popping -> no src_pop same cycle, one trailing dst_push, resume at next source in order when flag drops.
REQ-032 256 pushes from reset -> push_count returns to 0.
REQ-033 reset asserted the cycle after a pop -> dst_push stays 0, state=0001 immediately (asynchronous).

Source files
------------

// File: rtl/pop_referee_if.sv
// Bundle of the upstream/downstream FIFO signals that the pop referee arbitrates.
// The master side is the referee; the slave side is the FIFO fabric around it.
interface pop_referee_if #(
    parameter int LINE_SIZE = 12,
    parameter int NUM_SRC   = 4
);
    logic [NUM_SRC*LINE_SIZE-1:0] src_data;
    logic [NUM_SRC-1:0]           src_empty;
    logic [NUM_SRC-1:0]           src_pop;
    logic                         dst_almost_full;
    logic                         dst_push;
    logic [LINE_SIZE-1:0]         dst_data;

    modport master (
        input  src_data,
        input  src_empty,
        input  dst_almost_full,
        output src_pop,
        output dst_push,
        output dst_data
    );

    modport slave (
        output src_data,
        output src_empty,
        output dst_almost_full,
        input  src_pop,
        input  dst_push,
        input  dst_data
    );
endinterface

// File: rtl/pop_referee.sv
// Round-robin referee that pops lines from four upstream FIFOs and pushes them
// into one downstream FIFO. A pop in one cycle becomes a push in the next; the
// data is taken from the granted source's output line during the push cycle.
module pop_referee #(
    parameter int LINE_SIZE = 12,
    parameter int NUM_SRC   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    pop_referee_if.master       fifo,
    output logic [3:0]          state,
    output logic [1:0]          grant,
    output logic [7:0]          push_count
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   last_pop_q;   // sources popped last cycle (their empty flag is stale)
    logic                 pend_q;       // a pop was issued last cycle, push it now
    logic [1:0]           pend_idx_q;   // source whose line is pushed this cycle
    logic [1:0]           grant_q;
    logic [7:0]           count_q;
    logic [LINE_SIZE-1:0] hold_q;       // last pushed line, shown while idle

    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   pop_mask;
    logic                 pop_valid;
    logic [1:0]           pop_idx;
    logic [1:0]           cand;
    logic [LINE_SIZE-1:0] sel_data;

    // Round-robin search: first eligible source at or after grant+1, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pop_valid = 1'b0;
        pop_idx   = grant_q;
        cand      = grant_q;
        eligible  = '0;
        if (state_q == ST_ACTIVE && !fifo.dst_almost_full) begin
            eligible = ~fifo.src_empty & ~last_pop_q;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = grant_q + 2'(k) + 2'd1;
            if (!pop_valid && eligible[cand]) begin
                pop_valid = 1'b1;
                pop_idx   = cand;
            end
        end
        pop_mask = pop_valid ? (NUM_SRC'(1) << pop_idx) : '0;
    end

    // Next-state logic for the FIFO control state machine.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)                 state_d = ST_INIT;
                else if (!(&fifo.src_empty)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                  state_d = ST_INIT;
                else if ((&fifo.src_empty) && !pop_valid)  state_d = ST_IDLE;
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // Downstream line: live slice of the registered source during a push, held otherwise.
    always_comb begin
        sel_data = fifo.src_data[int'(pend_idx_q)*LINE_SIZE +: LINE_SIZE];
    end

    // State, arbitration and push bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            last_pop_q <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            grant_q    <= 2'd3;
            count_q    <= 8'd0;
            hold_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            last_pop_q <= pop_mask;
            pend_q     <= pop_valid;
            if (pop_valid) begin
                pend_idx_q <= pop_idx;
                grant_q    <= pop_idx;
            end
            if (pend_q) begin
                hold_q  <= sel_data;
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign fifo.src_pop  = pop_mask;
    assign fifo.dst_push = pend_q;
    assign fifo.dst_data = pend_q ? sel_data : hold_q;
    assign state         = state_q;
    assign grant         = grant_q;
    assign push_count    = count_q;

endmodule

// File: tb/tb_pop_referee.sv
// Directed testbench for pop_referee: reset sequencing, round-robin order,
// single-source alternation, almost-full throttling, init abort, counter wrap
// and asynchronous reset during a pending push.
module tb_pop_referee;

    localparam logic [3:0] S_RESET  = 4'b0001;
    localparam logic [3:0] S_INIT   = 4'b0010;
    localparam logic [3:0] S_IDLE   = 4'b0100;
    localparam logic [3:0] S_ACTIVE = 4'b1000;

    logic       clk;
    logic       reset;
    logic       init;
    logic [3:0] state;
    logic [1:0] grant;
    logic [7:0] push_count;

    logic [11:0] d [4] = '{12'h1A1, 12'h2B2, 12'h3C3, 12'h4D4};

    int checks = 0;
    int errors = 0;

    pop_referee_if #(.LINE_SIZE(12), .NUM_SRC(4)) bus ();

    pop_referee #(.LINE_SIZE(12), .NUM_SRC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .fifo       (bus),
        .state      (state),
        .grant      (grant),
        .push_count (push_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset = 1'b1;
        init  = 1'b1;
        bus.src_empty       = 4'hF;
        bus.dst_almost_full = 1'b0;
        bus.src_data        = {d[3], d[2], d[1], d[0]};
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== S_RESET) begin errors++; $display("FAIL reset_state: got %b expected %b", state, S_RESET); end
        checks++; if (bus.src_pop !== 4'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0000", bus.src_pop); end
        checks++; if (bus.dst_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b expected 0", bus.dst_push); end
        checks++; if (bus.dst_data !== 12'h0) begin errors++; $display("FAIL reset_data: got %h expected 000", bus.dst_data); end
        checks++; if (grant !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d expected 3", grant); end
        checks++; if (push_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", push_count); end
        reset = 1'b0;
        #1;
        checks++; if (state !== S_RESET) begin errors++; $display("FAIL release_state: got %b expected %b", state, S_RESET); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (state !== S_INIT) begin errors++; $display("FAIL init_hold[%0d]: got %b expected %b", i, state, S_INIT); end
            if (i == 2) init = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if (state !== S_IDLE) begin errors++; $display("FAIL idle_hold[%0d]: got %b expected %b", i, state, S_IDLE); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_pop;
        @(negedge clk);
        bus.src_empty = 4'h0;
        #1;
        checks++; if (bus.src_pop !== 4'b0) begin errors++; $display("FAIL rr_idle_pop: got %b expected 0000", bus.src_pop); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) bus.src_empty = 4'hF;
            #1;
            exp_pop = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
            checks++; if (state !== S_ACTIVE) begin errors++; $display("FAIL rr_state[%0d]: got %b expected %b", k, state, S_ACTIVE); end
            checks++; if (bus.src_pop !== exp_pop) begin errors++; $display("FAIL rr_pop[%0d]: got %b expected %b", k, bus.src_pop, exp_pop); end
            checks++; if (bus.dst_push !== (k > 0)) begin errors++; $display("FAIL rr_push[%0d]: got %b expected %b", k, bus.dst_push, (k > 0)); end
            if (k > 0) begin
                checks++; if (bus.dst_data !== d[(k-1) % 4]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, bus.dst_data, d[(k-1) % 4]); end
            end
        end
        @(negedge clk); #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL rr_back_idle: got %b expected %b", state, S_IDLE); end
        checks++; if (bus.dst_push !== 1'b0) begin errors++; $display("FAIL rr_idle_push: got %b expected 0", bus.dst_push); end
        checks++; if (bus.dst_data !== d[0]) begin errors++; $display("FAIL rr_hold_data: got %h expected %h", bus.dst_data, d[0]); end
        checks++; if (push_count !== 8'd5) begin errors++; $display("FAIL rr_count: got %0d expected 5", push_count); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rr_grant: got %0d expected 0", grant); end
    endtask

    task automatic test_single_source();
        logic [3:0] pops [5] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        logic       push [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        bus.src_empty = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) bus.src_empty = 4'hF;
            #1;
            checks++; if (bus.src_pop !== pops[k]) begin errors++; $display("FAIL single_pop[%0d]: got %b expected %b", k, bus.src_pop, pops[k]); end
            checks++; if (bus.dst_push !== push[k]) begin errors++; $display("FAIL single_push[%0d]: got %b expected %b", k, bus.dst_push, push[k]); end
            if (push[k]) begin
                checks++; if (bus.dst_data !== d[2]) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, bus.dst_data, d[2]); end
            end
        end
        @(negedge clk); #1;
        checks++; if (push_count !== 8'd7) begin errors++; $display("FAIL single_count: got %0d expected 7", push_count); end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL single_idle: got %b expected %b", state, S_IDLE); end
    endtask

    task automatic test_almost_full();
        logic [3:0]  pops [7] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
        logic        push [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [11:0] data [7] = '{12'h0, d[3], d[0], 12'h0, 12'h0, d[1], d[2]};
        @(negedge clk);
        bus.src_empty = 4'h0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 2) bus.dst_almost_full = 1'b1;
            if (k == 4) bus.dst_almost_full = 1'b0;
            if (k == 6) bus.src_empty = 4'hF;
            #1;
            checks++; if (bus.src_pop !== pops[k]) begin errors++; $display("FAIL af_pop[%0d]: got %b expected %b", k, bus.src_pop, pops[k]); end
            checks++; if (bus.dst_push !== push[k]) begin errors++; $display("FAIL af_push[%0d]: got %b expected %b", k, bus.dst_push, push[k]); end
            if (push[k]) begin
                checks++; if (bus.dst_data !== data[k]) begin errors++; $display("FAIL af_data[%0d]: got %h expected %h", k, bus.dst_data, data[k]); end
            end
        end
        @(negedge clk); #1;
        checks++; if (push_count !== 8'd11) begin errors++; $display("FAIL af_count: got %0d expected 11", push_count); end
        checks++; if (grant !== 2'd2) begin errors++; $display("FAIL af_grant: got %0d expected 2", grant); end
    endtask

    task automatic test_init_abort();
        @(negedge clk);
        bus.src_empty = 4'h0;
        @(negedge clk);
        init = 1'b1;
        #1;
        checks++; if (bus.src_pop !== 4'b1000) begin errors++; $display("FAIL abort_pop: got %b expected 1000", bus.src_pop); end
        @(negedge clk);
        init = 1'b0;
        bus.src_empty = 4'hF;
        #1;
        checks++; if (state !== S_INIT) begin errors++; $display("FAIL abort_state: got %b expected %b", state, S_INIT); end
        checks++; if (bus.src_pop !== 4'b0) begin errors++; $display("FAIL abort_no_pop: got %b expected 0000", bus.src_pop); end
        checks++; if (bus.dst_push !== 1'b1) begin errors++; $display("FAIL abort_trailing_push: got %b expected 1", bus.dst_push); end
        checks++; if (bus.dst_data !== d[3]) begin errors++; $display("FAIL abort_data: got %h expected %h", bus.dst_data, d[3]); end
        @(negedge clk); #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL abort_idle: got %b expected %b", state, S_IDLE); end
        checks++; if (bus.dst_push !== 1'b0) begin errors++; $display("FAIL abort_push_done: got %b expected 0", bus.dst_push); end
        checks++; if (push_count !== 8'd12) begin errors++; $display("FAIL abort_count: got %0d expected 12", push_count); end
    endtask

    task automatic test_count_wrap();
        int         seen = 0;
        logic [3:0] exp_pop;
        logic [7:0] exp_cnt;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (push_count !== 8'd0) begin errors++; $display("FAIL wrap_reset_count: got %0d expected 0", push_count); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL wrap_idle: got %b expected %b", state, S_IDLE); end
        bus.src_empty = 4'h0;
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk);
            if (k == 256) bus.src_empty = 4'hF;
            #1;
            exp_pop = (k < 256) ? (4'b0001 << (k % 4)) : 4'b0000;
            exp_cnt = (k > 0) ? 8'(k - 1) : 8'd0;
            if (bus.dst_push === 1'b1) seen++;
            checks++; if (bus.src_pop !== exp_pop) begin errors++; $display("FAIL wrap_pop[%0d]: got %b expected %b", k, bus.src_pop, exp_pop); end
            checks++; if (push_count !== exp_cnt) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, push_count, exp_cnt); end
        end
        @(negedge clk); #1;
        checks++; if (seen != 256) begin errors++; $display("FAIL wrap_pushes: got %0d expected 256", seen); end
        checks++; if (push_count !== 8'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", push_count); end
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL wrap_end_idle: got %b expected %b", state, S_IDLE); end
        checks++; if (grant !== 2'd3) begin errors++; $display("FAIL wrap_grant: got %0d expected 3", grant); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.src_empty = 4'h0;
        @(negedge clk); #1;
        checks++; if (bus.src_pop !== 4'b0001) begin errors++; $display("FAIL midrst_pop: got %b expected 0001", bus.src_pop); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (state !== S_RESET) begin errors++; $display("FAIL midrst_state: got %b expected %b", state, S_RESET); end
        checks++; if (bus.dst_push !== 1'b0) begin errors++; $display("FAIL midrst_push: got %b expected 0", bus.dst_push); end
        checks++; if (bus.src_pop !== 4'b0) begin errors++; $display("FAIL midrst_no_pop: got %b expected 0000", bus.src_pop); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (bus.dst_push !== 1'b0) begin errors++; $display("FAIL midrst_hold_push[%0d]: got %b expected 0", k, bus.dst_push); end
        end
        checks++; if (push_count !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", push_count); end
        bus.src_empty = 4'hF;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_recover: got %b expected %b", state, S_IDLE); end
        checks++; if (bus.dst_push !== 1'b0) begin errors++; $display("FAIL midrst_recover_push: got %b expected 0", bus.dst_push); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_source();
        test_almost_full();
        test_init_abort();
        test_count_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
